// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD FSM with a one-word hold buffer, and the IF/ID register.
// Optional BRANCH_DELAY_SLOT_EN lets the instruction accepted in the branch cycle enter IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic [5:0]  opcode
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc_plus4;
   logic [31:0] hold_buf, hold_nxt;
   logic [31:0] instr_nxt, pc4_nxt;
   logic        valid_nxt;

   assign pc_plus4  = pc + 32'd4;
   // reset_n gates the request so it stays low for the whole reset interval
   assign imem_req  = reset_n && (state == FETCH);
   assign imem_addr = pc;
   assign opcode    = ifid_instr[31:26];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         hold_buf   <= '0;
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc4   <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         hold_buf   <= hold_nxt;
         ifid_valid <= valid_nxt;
         ifid_instr <= instr_nxt;
         ifid_pc4   <= pc4_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_nxt  = hold_buf;
      valid_nxt = ifid_valid;
      instr_nxt = ifid_instr;
      pc4_nxt   = ifid_pc4;

      case (state)
         FETCH: begin
            if (imem_valid) begin
               if (!stall) begin
                  valid_nxt = 1'b1;
                  instr_nxt = imem_rdata;
                  pc4_nxt   = pc_plus4;
                  pc_nxt    = pc_plus4;
               end else begin
                  hold_nxt  = imem_rdata;
                  state_nxt = HOLD;
               end
            end else if (!stall) begin
               valid_nxt = 1'b0;
            end
         end
         HOLD: begin
            if (!stall) begin
               valid_nxt = 1'b1;
               instr_nxt = hold_buf;
               pc4_nxt   = pc_plus4;
               pc_nxt    = pc_plus4;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase

      // Redirect overrides everything above, including stall
      if (branch_taken) begin
         pc_nxt    = {branch_target[31:2], 2'b00};
         state_nxt = FETCH;
         hold_nxt  = hold_buf;
`ifdef BRANCH_DELAY_SLOT_EN
         if (!((state == FETCH && imem_valid && !stall) || (state == HOLD && !stall)))
            valid_nxt = 1'b0;
`else
         valid_nxt = 1'b0;
         instr_nxt = ifid_instr;
         pc4_nxt   = ifid_pc4;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance covers RESET_PC wrap-around.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n, stall, branch_taken, imem_valid;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, ifid_valid, w_req, w_valid;
   logic [31:0] imem_addr, ifid_instr, ifid_pc4, w_addr, w_instr, w_pc4;
   logic [5:0]  opcode, w_opcode;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .opcode(opcode)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(w_req), .imem_addr(w_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ifid_valid(w_valid),
      .ifid_instr(w_instr), .ifid_pc4(w_pc4), .opcode(w_opcode)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
      branch_target = '0; imem_rdata = '0;
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", ifid_instr); end
      checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", ifid_pc4); end
      checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_waddr got %h exp fffffffc", w_addr); end
      reset_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b exp 1", imem_req); end
   endtask

   task automatic test_throughput();
      imem_valid = 1'b1; imem_rdata = 32'h2008_0005;
      tick();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL tp_addr1 got %h exp 4", imem_addr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL tp_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_pc4 !== 32'h4) begin errors++; $display("FAIL tp_pc4 got %h exp 4", ifid_pc4); end
      checks++; if (opcode !== 6'b001000) begin errors++; $display("FAIL tp_opcode got %b exp 001000", opcode); end
      tick();
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL tp_addr2 got %h exp 8", imem_addr); end
      checks++; if (ifid_pc4 !== 32'h8) begin errors++; $display("FAIL tp_pc4b got %h exp 8", ifid_pc4); end
      imem_valid = 1'b0;
      tick();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_pc4 !== 32'h8) begin errors++; $display("FAIL bubble_pc4 got %h exp 8", ifid_pc4); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bubble_addr got %h exp 8", imem_addr); end
   endtask

   task automatic test_stall_hold();
      stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h8C09_0000;
      tick();
      imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", imem_req); end
      checks++; if (ifid_instr !== 32'h2008_0005) begin errors++; $display("FAIL hold_instr got %h exp 20080005", ifid_instr); end
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req3 got %b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL hold_addr got %h exp 8", imem_addr); end
      stall = 1'b0;
      tick();
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_instr !== 32'h8C09_0000) begin errors++; $display("FAIL rel_instr got %h exp 8c090000", ifid_instr); end
      checks++; if (opcode !== 6'b100011) begin errors++; $display("FAIL rel_opcode got %b exp 100011", opcode); end
      checks++; if (ifid_pc4 !== 32'hC) begin errors++; $display("FAIL rel_pc4 got %h exp c", ifid_pc4); end
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL rel_addr got %h exp c", imem_addr); end
      // Fetch miss while stalled leaves IF/ID intact
      stall = 1'b1;
      tick();
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stallmiss_valid got %b exp 1", ifid_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stallmiss_req got %b exp 1", imem_req); end
   endtask

   task automatic test_branch_stall();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043;
      imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      branch_taken = 1'b0; stall = 1'b0; imem_valid = 1'b0;
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL brs_addr got %h exp 40", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL brs_valid got %b exp 0", ifid_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL brs_req got %b exp 1", imem_req); end
      checks++; if (ifid_instr !== 32'h8C09_0000) begin errors++; $display("FAIL brs_instr got %h exp 8c090000", ifid_instr); end
   endtask

   task automatic test_branch_accept();
      branch_taken = 1'b1; branch_target = 32'h0000_0100;
      imem_valid = 1'b1; imem_rdata = 32'hAC0A_0004;
      tick();
      branch_taken = 1'b0; imem_valid = 1'b0;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bra_addr got %h exp 100", imem_addr); end
`ifdef BRANCH_DELAY_SLOT_EN
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL bra_valid got %b exp 1", ifid_valid); end
      checks++; if (ifid_instr !== 32'hAC0A_0004) begin errors++; $display("FAIL bra_instr got %h exp ac0a0004", ifid_instr); end
      checks++; if (ifid_pc4 !== 32'h44) begin errors++; $display("FAIL bra_pc4 got %h exp 44", ifid_pc4); end
`else
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bra_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h8C09_0000) begin errors++; $display("FAIL bra_instr got %h exp 8c090000", ifid_instr); end
      checks++; if (ifid_pc4 !== 32'hC) begin errors++; $display("FAIL bra_pc4 got %h exp c", ifid_pc4); end
`endif
   endtask

   task automatic test_branch_from_hold();
      stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bh_hold_req got %b exp 0", imem_req); end
      imem_valid = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0202;
      tick();
      branch_taken = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bh_req got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL bh_addr got %h exp 200", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bh_valid got %b exp 0", ifid_valid); end
      stall = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h2222_2222;
      tick();
      imem_valid = 1'b0;
      checks++; if (ifid_instr !== 32'h2222_2222) begin errors++; $display("FAIL bh_instr got %h exp 22222222", ifid_instr); end
      checks++; if (ifid_pc4 !== 32'h204) begin errors++; $display("FAIL bh_pc4 got %h exp 204", ifid_pc4); end
   endtask

   task automatic test_latency();
      tick(); tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL lat_addr got %h exp 204", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL lat_valid got %b exp 0", ifid_valid); end
      imem_valid = 1'b1; imem_rdata = 32'h3333_3333;
      tick();
      imem_valid = 1'b0;
      checks++; if (ifid_instr !== 32'h3333_3333) begin errors++; $display("FAIL lat_instr got %h exp 33333333", ifid_instr); end
      checks++; if (ifid_pc4 !== 32'h208) begin errors++; $display("FAIL lat_pc4 got %h exp 208", ifid_pc4); end
   endtask

   task automatic test_reset_mid_fetch();
      tick(); tick();
      reset_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mrst_req got %b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mrst_addr got %h exp 0", imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL mrst_instr got %h exp 0", ifid_instr); end
      imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_valid = 1'b0;
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL late_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL late_instr got %h exp 0", ifid_instr); end
      reset_n = 1'b1;
      #1;
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mrel_addr got %h exp 0", imem_addr); end
   endtask

   task automatic test_wrap();
      checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffffc", w_addr); end
      imem_valid = 1'b1; imem_rdata = 32'h2008_0005;
      tick();
      imem_valid = 1'b0;
      checks++; if (w_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", w_pc4); end
      checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", w_addr); end
      checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", w_valid); end
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_stall_hold();
      test_branch_stall();
      test_branch_accept();
      test_branch_from_hold();
      test_latency();
      test_reset_mid_fetch();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
